// File: rtl/gcn_pkg.sv
// ---------------------------------------------------------------------------
// gcn_pkg
// Shared constants and types for the GCN matrix-multiply datapath.
//   ELEM_W      : element width in bits
//   ROWS, COLS  : dimensions of one matrix block
//   SEG_ELEMS   : elements per block (one segment of a frame)
//   FRAME_ELEMS : elements per operand frame (F upper, F lower, W)
//   F_W, W_W    : flat feature / weight vector widths
//   RES_W       : width of the multiply result bus downstream
// ---------------------------------------------------------------------------
package gcn_pkg;

    localparam int ELEM_W      = 5;
    localparam int ROWS        = 96;
    localparam int COLS        = 3;
    localparam int SEG_ELEMS   = ROWS * COLS;            // 288
    localparam int FRAME_ELEMS = 3 * SEG_ELEMS;          // 864
    localparam int F_W         = 2 * SEG_ELEMS * ELEM_W; // 2880
    localparam int W_W         = SEG_ELEMS * ELEM_W;     // 1440
    localparam int RES_W       = 306;
    localparam int CNT_W       = 10;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/gcn_operand_packer.sv
// ---------------------------------------------------------------------------
// gcn_operand_packer
// Loads a stream of ELEM_W-bit elements into the flat operand vectors of the
// GCN multiply block. A frame is 864 elements: 288 into the upper half of F,
// 288 into the lower half of F, then 288 into W, each segment LSB-first.
// The completed frame is then held stable until the consumer takes it.
//
// Ports
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   clr        : synchronous frame abort (back to FILL, counter to 0)
//   s_valid    : input element valid
//   s_ready    : packer accepts an element (high in FILL)
//   s_data     : element value
//   s_last     : final element of a frame
//   f_out      : feature vector, 2*ROWS*COLS*ELEM_W bits
//   w_out      : weight vector, ROWS*COLS*ELEM_W bits
//   m_valid    : f_out/w_out hold a complete frame (high in HOLD)
//   m_ready    : consumer takes the frame
//   err_len    : one-cycle pulse after a frame-length error
// ---------------------------------------------------------------------------
module gcn_operand_packer
    import gcn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ELEM_W-1:0] s_data,
    input  logic              s_last,
    output logic [F_W-1:0]    f_out,
    output logic [W_W-1:0]    w_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              err_len
);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_ELEMS - 1);
    localparam logic [CNT_W-1:0] SEG1_BASE = CNT_W'(SEG_ELEMS);
    localparam logic [CNT_W-1:0] SEG2_BASE = CNT_W'(2 * SEG_ELEMS);
    localparam int               SEG_BITS  = SEG_ELEMS * ELEM_W;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
    logic [F_W-1:0]   f_reg;
    logic [W_W-1:0]   w_reg;

    logic             accept;
    logic [1:0]       seg_sel;
    logic [CNT_W-1:0] slot_k;

    // clr overrides any accept in the same cycle, so the element is dropped
    assign accept = s_valid && (state_reg == FILL) && !clr;

    // Segment and slot decode from the element counter
    always_comb begin
        seg_sel = 2'd0;
        slot_k  = cnt_reg;
        if (cnt_reg >= SEG2_BASE) begin
            seg_sel = 2'd2;
            slot_k  = cnt_reg - SEG2_BASE;
        end else if (cnt_reg >= SEG1_BASE) begin
            seg_sel = 2'd1;
            slot_k  = cnt_reg - SEG1_BASE;
        end
    end

    // Frame sequencing: counter, state and length-error detection
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        if (clr) begin
            state_next = FILL;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (s_valid) begin
                        if (cnt_reg == LAST_IDX) begin
                            // Full frame delivered even when s_last is missing
                            state_next = HOLD;
                            cnt_next   = '0;
                            err_next   = !s_last;
                        end else if (s_last) begin
                            // Early last: drop the partial frame, restart
                            cnt_next = '0;
                            err_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        state_next = FILL;
                    end
                end
                default: state_next = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FILL;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    // Operand storage: only the addressed slot is written; everything else
    // holds, and nothing is written outside FILL so the frame stays frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_reg <= '0;
            w_reg <= '0;
        end else if (accept) begin
            case (seg_sel)
                2'd0:    f_reg[SEG_BITS + int'(slot_k) * ELEM_W +: ELEM_W] <= s_data;
                2'd1:    f_reg[int'(slot_k) * ELEM_W +: ELEM_W]            <= s_data;
                default: w_reg[int'(slot_k) * ELEM_W +: ELEM_W]            <= s_data;
            endcase
        end
    end

    assign s_ready = (state_reg == FILL);
    assign m_valid = (state_reg == HOLD);
    assign err_len = err_reg;
    assign f_out   = f_reg;
    assign w_out   = w_reg;

endmodule

// File: tb/tb_gcn_operand_packer.sv
// ---------------------------------------------------------------------------
// tb_gcn_operand_packer
// Directed stimulus for gcn_operand_packer. The driver keeps a reference
// image of F and W built from the slot mapping and pushes each expected
// output event (delivered frame and/or length-error pulse) into a queue; an
// independent monitor pops and compares whenever the DUT raises m_valid or
// err_len. Timing and boundary checks sit next to the stimulus.
// ---------------------------------------------------------------------------
module tb_gcn_operand_packer;
    import gcn_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [ELEM_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic [F_W-1:0]    f_out;
    logic [W_W-1:0]    w_out;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic              err_len;

    gcn_operand_packer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .f_out   (f_out),
        .w_out   (w_out),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .err_len (err_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit             frame;
        bit             err;
        logic [F_W-1:0] f;
        logic [W_W-1:0] w;
    } ev_t;

    ev_t            sb[$];
    logic [F_W-1:0] exp_f = '0;
    logic [W_W-1:0] exp_w = '0;
    int             tb_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [F_W-1:0] act,
                           input logic [F_W-1:0] exp, input int nslots);
        int bad;
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            bad = -1;
            for (int k = 0; k < nslots; k++)
                if (bad < 0 && act[5*k +: 5] !== exp[5*k +: 5]) bad = k;
            if (bad < 0) bad = 0;
            $display("FAIL %s: slot at bit %0d got %0d, expected %0d",
                     name, 5*bad, act[5*bad +: 5], exp[5*bad +: 5]);
        end
    endtask

    // Reference slot mapping
    task automatic model_write(input int c, input logic [4:0] d);
        if (c < 288)      exp_f[1440 + 5*c +: 5] = d;
        else if (c < 576) exp_f[5*(c-288) +: 5]  = d;
        else              exp_w[5*(c-576) +: 5]  = d;
    endtask

    // Offer one element from a negedge; returns at the negedge after accept
    task automatic push(input logic [4:0] d, input logic l);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, t);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_write(tb_cnt, d);
        if (tb_cnt == 863) begin
            sb.push_back('{frame: 1'b1, err: !l, f: exp_f, w: exp_w});
            tb_cnt = 0;
        end else if (l) begin
            sb.push_back('{frame: 1'b0, err: 1'b1, f: exp_f, w: exp_w});
            tb_cnt = 0;
        end else begin
            tb_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Monitor: one event per m_valid rise or err_len pulse
    initial begin
        ev_t  e;
        logic mv_prev;
        mv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mv_prev = 1'b0;
            end else begin
                if (err_len || (m_valid && !mv_prev)) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mon_unexpected: m_valid=%0b err_len=%0b with no event pending",
                                 m_valid, err_len);
                    end else begin
                        e = sb.pop_front();
                        $display("mon: event frame=%0b err=%0b at %0t", e.frame, e.err, $time);
                        chk("mon_m_valid", 32'(m_valid), 32'(e.frame));
                        chk("mon_err_len", 32'(err_len), 32'(e.err));
                        if (e.frame) begin
                            chk_vec("mon_f_out", f_out, e.f, 2*SEG_ELEMS);
                            chk_vec("mon_w_out", {{W_W{1'b0}}, w_out}, {{W_W{1'b0}}, e.w}, SEG_ELEMS);
                        end
                    end
                end
                mv_prev = m_valid;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] old_slot;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_err_len", 32'(err_len), 32'd0);
        chk_vec("rst_f_out", f_out, '0, 2*SEG_ELEMS);
        chk_vec("rst_w_out", {{W_W{1'b0}}, w_out}, '0, SEG_ELEMS);

        // T1: full frame, data = cnt mod 32, m_ready high
        for (int i = 0; i < 864; i++) push(5'(i % 32), i == 863);
        idle_inputs();
        $display("t1: frame sent, m_valid=%0b", m_valid);
        chk("t1_m_valid_rise", 32'(m_valid), 32'd1);
        chk("t1_s_ready_low", 32'(s_ready), 32'd0);
        chk("t1_f_1444_1440", 32'(f_out[1444:1440]), 32'd0);
        chk("t1_f_2879_2875", 32'(f_out[2879:2875]), 32'd31);
        chk("t1_f_4_0", 32'(f_out[4:0]), 32'd0);
        chk("t1_w_4_0", 32'(w_out[4:0]), 32'd0);
        chk("t1_w_1439_1435", 32'(w_out[1439:1435]), 32'd31);
        @(negedge clk);
        chk("t1_m_valid_one_cycle", 32'(m_valid), 32'd0);
        chk("t1_s_ready_back", 32'(s_ready), 32'd1);

        // T2: back-pressure in HOLD, inputs ignored while s_ready is low
        m_ready = 1'b0;
        for (int i = 0; i < 864; i++) push(5'((i*3 + 1) % 32), i == 863);
        s_valid = 1'b1;
        s_data  = 5'h1f;
        s_last  = 1'b1;
        $display("t2: frame sent, holding m_ready low");
        for (int c = 0; c < 20; c++) begin
            chk("t2_hold_m_valid", 32'(m_valid), 32'd1);
            chk("t2_hold_s_ready", 32'(s_ready), 32'd0);
            chk_vec("t2_hold_f_out", f_out, exp_f, 2*SEG_ELEMS);
            chk_vec("t2_hold_w_out", {{W_W{1'b0}}, w_out}, {{W_W{1'b0}}, exp_w}, SEG_ELEMS);
            @(negedge clk);
        end
        idle_inputs();
        m_ready = 1'b1;
        @(negedge clk);
        chk("t2_release_m_valid", 32'(m_valid), 32'd0);
        chk("t2_release_s_ready", 32'(s_ready), 32'd1);

        // T3: early s_last on element 100, then a clean frame
        for (int i = 0; i <= 100; i++) push(5'((i + 5) % 32), i == 100);
        idle_inputs();
        $display("t3: early last sent, err_len=%0b", err_len);
        chk("t3_err_pulse", 32'(err_len), 32'd1);
        chk("t3_no_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t3_err_one_cycle", 32'(err_len), 32'd0);
        chk("t3_s_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 864; i++) push(5'((i*7 + 3) % 32), i == 863);
        idle_inputs();
        @(negedge clk);

        // T4: 864 elements without s_last
        for (int i = 0; i < 864; i++) push(5'((i*5 + 2) % 32), 1'b0);
        idle_inputs();
        $display("t4: frame without last, m_valid=%0b err_len=%0b", m_valid, err_len);
        chk("t4_m_valid", 32'(m_valid), 32'd1);
        chk("t4_err_same_cycle", 32'(err_len), 32'd1);
        @(negedge clk);
        chk("t4_err_one_cycle", 32'(err_len), 32'd0);

        // T5: clr together with the accept at cnt = 400
        for (int i = 0; i < 400; i++) push(5'((i*11) % 32), 1'b0);
        old_slot = exp_f[560 +: 5];
        s_valid  = 1'b1;
        s_data   = ~old_slot;
        s_last   = 1'b0;
        clr      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        idle_inputs();
        tb_cnt = 0;
        $display("t5: clr at cnt 400, slot f[564:560]=%0d", f_out[564:560]);
        chk("t5_clr_s_ready", 32'(s_ready), 32'd1);
        chk("t5_clr_m_valid", 32'(m_valid), 32'd0);
        chk("t5_discarded_slot", 32'(f_out[564:560]), 32'(old_slot));
        push(5'h0b, 1'b0);
        idle_inputs();
        chk("t5_first_after_clr", 32'(f_out[1444:1440]), 32'd11);
        chk("t5_discarded_slot_2", 32'(f_out[564:560]), 32'(old_slot));
        for (int i = 1; i < 864; i++) push(5'((i*13) % 32), i == 863);
        idle_inputs();
        @(negedge clk);

        // T6: asynchronous reset at cnt = 500 with s_valid high
        for (int i = 0; i < 500; i++) push(5'((i + 9) % 32), 1'b0);
        s_valid = 1'b1;
        s_data  = 5'd7;
        #2;
        rst_n = 1'b0;
        #1;
        $display("t6: reset asserted mid-frame");
        chk("t6_rst_s_ready", 32'(s_ready), 32'd1);
        chk("t6_rst_m_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_err_len", 32'(err_len), 32'd0);
        chk_vec("t6_rst_f_out", f_out, '0, 2*SEG_ELEMS);
        chk_vec("t6_rst_w_out", {{W_W{1'b0}}, w_out}, '0, SEG_ELEMS);
        exp_f  = '0;
        exp_w  = '0;
        tb_cnt = 0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_after_s_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 864; i++) push(5'((i*17 + 4) % 32), i == 863);
        idle_inputs();
        repeat (3) @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
